// File: rtl/sd_cmd_sequencer_if.sv
// Command-request and SPI byte-engine signals of the SD command sequencer.
// The sequencer connects through the master modport; requester and byte engine use slave.
interface sd_cmd_sequencer_if;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_long_resp;
    logic        cmd_busy;
    logic        cmd_done;
    logic        cmd_timeout;
    logic [7:0]  resp_r1;
    logic [31:0] resp_data;
    logic        cs_n;
    logic        spi_execute;
    logic [7:0]  spi_out_word;
    logic [7:0]  spi_in_word;
    logic        spi_finished;

    modport master (
        input  cmd_start, cmd_index, cmd_arg, cmd_long_resp, spi_in_word, spi_finished,
        output cmd_busy, cmd_done, cmd_timeout, resp_r1, resp_data,
        output cs_n, spi_execute, spi_out_word
    );

    modport slave (
        output cmd_start, cmd_index, cmd_arg, cmd_long_resp, spi_in_word, spi_finished,
        input  cmd_busy, cmd_done, cmd_timeout, resp_r1, resp_data,
        input  cs_n, spi_execute, spi_out_word
    );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// Runs one SPI-mode SD command: lead byte, CRC7-protected frame, R1 poll,
// optional 4-byte trailer and a trailing gap byte, framed by chip select.
module sd_cmd_sequencer #(
    parameter int unsigned RESP_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sd_cmd_sequencer_if.master   bus
);
    localparam logic [7:0] TIMEOUT_CNT = 8'(RESP_TIMEOUT);

    typedef enum logic [2:0] {IDLE, LEAD, SEND, POLL, TRAIL, GAP, DONE} state_t;
    typedef enum logic [1:0] {PH_ARM, PH_ISSUE, PH_WAIT} phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [2:0]  byte_q, byte_d;
    logic [7:0]  poll_q, poll_d;
    logic        cs_n_q, cs_n_d;
    logic [7:0]  out_q, out_d;
    logic        done_q, done_d;
    logic        tmo_q, tmo_d;
    logic [7:0]  r1_q, r1_d;
    logic [31:0] data_q, data_d;
    logic [6:0]  crc_q, crc_d;
    logic        accept;

    logic [5:0]  idx_q;
    logic [31:0] arg_q;
    logic        long_q;

    // CRC7, polynomial x^7+x^3+1, zero init, MSB first over the 40 header bits.
    function automatic logic [6:0] crc7(input logic [39:0] bits);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = bits[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] n, input logic [5:0] idx,
                                              input logic [31:0] arg, input logic [6:0] crc);
        case (n)
            3'd0:    return {2'b01, idx};
            3'd1:    return arg[31:24];
            3'd2:    return arg[23:16];
            3'd3:    return arg[15:8];
            3'd4:    return arg[7:0];
            default: return {crc, 1'b1};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= PH_ARM;
            byte_q  <= '0;
            poll_q  <= '0;
            cs_n_q  <= 1'b1;
            out_q   <= 8'hFF;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            r1_q    <= 8'hFF;
            data_q  <= '0;
            crc_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            byte_q  <= byte_d;
            poll_q  <= poll_d;
            cs_n_q  <= cs_n_d;
            out_q   <= out_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            r1_q    <= r1_d;
            data_q  <= data_d;
            crc_q   <= crc_d;
        end
    end

    // Command fields are only meaningful while busy, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q  <= bus.cmd_index;
            arg_q  <= bus.cmd_arg;
            long_q <= bus.cmd_long_resp;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        byte_d  = byte_q;
        poll_d  = poll_q;
        cs_n_d  = cs_n_q;
        out_d   = out_q;
        done_d  = 1'b0;
        tmo_d   = tmo_q;
        r1_d    = r1_q;
        data_d  = data_q;
        crc_d   = crc_q;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_start) begin
                    accept  = 1'b1;
                    state_d = LEAD;
                    phase_d = PH_ARM;
                    cs_n_d  = 1'b0;
                    tmo_d   = 1'b0;
                    data_d  = '0;
                    out_d   = 8'hFF;
                    byte_d  = '0;
                    poll_d  = '0;
                    crc_d   = crc7({2'b01, bus.cmd_index, bus.cmd_arg});
                end
            end
            DONE: state_d = IDLE;
            default: begin
                case (phase_q)
                    PH_ARM:   phase_d = PH_ISSUE;
                    PH_ISSUE: phase_d = PH_WAIT;
                    default: begin
                        if (bus.spi_finished) begin
                            phase_d = PH_ISSUE;
                            case (state_q)
                                LEAD: begin
                                    state_d = SEND;
                                    byte_d  = '0;
                                    out_d   = frame_byte(3'd0, idx_q, arg_q, crc_q);
                                end
                                SEND: begin
                                    if (byte_q == 3'd5) begin
                                        state_d = POLL;
                                        out_d   = 8'hFF;
                                    end else begin
                                        byte_d = byte_q + 3'd1;
                                        out_d  = frame_byte(byte_q + 3'd1, idx_q, arg_q, crc_q);
                                    end
                                end
                                POLL: begin
                                    poll_d = poll_q + 8'd1;
                                    if (!bus.spi_in_word[7]) begin
                                        r1_d    = bus.spi_in_word;
                                        byte_d  = '0;
                                        state_d = long_q ? TRAIL : GAP;
                                    end else if (poll_q + 8'd1 == TIMEOUT_CNT) begin
                                        r1_d    = 8'hFF;
                                        tmo_d   = 1'b1;
                                        state_d = GAP;
                                    end
                                end
                                TRAIL: begin
                                    data_d = {data_q[23:0], bus.spi_in_word};
                                    if (byte_q == 3'd3) state_d = GAP;
                                    else                byte_d  = byte_q + 3'd1;
                                end
                                GAP: begin
                                    state_d = DONE;
                                    phase_d = PH_ARM;
                                    cs_n_d  = 1'b1;
                                    done_d  = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        endcase
    end

    assign bus.spi_execute  = (phase_q == PH_ISSUE) && (state_q != IDLE) && (state_q != DONE);
    assign bus.spi_out_word = out_q;
    assign bus.cs_n         = cs_n_q;
    assign bus.cmd_busy     = (state_q != IDLE);
    assign bus.cmd_done     = done_q;
    assign bus.cmd_timeout  = tmo_q;
    assign bus.resp_r1      = r1_q;
    assign bus.resp_data    = data_q;
endmodule
